// File: rtl/keypad_emulator_pkg.sv
// Shared definitions for the 4x4 keypad emulator: game key codes, the
// emulator FSM state encoding and the contact-per-state rule.
package keypad_emulator_pkg;

    // Key codes as seen by the 2048 game (row = code[3:2], column = code[1:0]).
    localparam logic [3:0] KEY_LEFT  = 4'd1;
    localparam logic [3:0] KEY_RIGHT = 4'd3;
    localparam logic [3:0] KEY_UP    = 4'd6;
    localparam logic [3:0] KEY_DOWN  = 4'd2;

    // Emulator FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_BIN  = 3'd1,
        ST_HOLD = 3'd2,
        ST_BOUT = 3'd3,
        ST_GAP  = 3'd4
    } kp_state_e;

    // Contact is closed on even press-bounce phases, throughout HOLD,
    // and on odd release-bounce phases; open everywhere else.
    function automatic logic contact_of(input kp_state_e st, input logic phase_odd);
        logic c;
        c = 1'b0;
        case (st)
            ST_BIN:  c = ~phase_odd;
            ST_HOLD: c = 1'b1;
            ST_BOUT: c = phase_odd;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/keypad_emulator_tick.sv
// Timing-tick prescaler: emits a one-clk tick every TICK_DIV clks,
// counted from the last synchronous clear.
module keypad_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);
    // The clear cycle itself never ticks, so the first tick lands TICK_DIV clks later.
    assign o_tick = w_wrap && !i_clear;

    // Free-running divider, restarted by a clear or on reaching its last count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// Passive 4x4 matrix keypad model. Accepts press commands, plays out press
// bounce, hold, release bounce and a quiet gap, and returns the addressed row
// low whenever the modelled contact is closed and its column is strobed.
module keypad_emulator
    import keypad_emulator_pkg::*;
#(
    parameter int TICK_DIV       = 50000,
    parameter int BOUNCE_TOGGLES = 4,
    parameter int BOUNCE_TICKS   = 1,
    parameter int GAP_TICKS      = 20,
    parameter int HOLD_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_code,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [3:0]        col,
    output logic [3:0]        row,
    output logic              busy,
    output logic              contact,
    output logic              done
);

    // Bounce phase count per edge; at least 1 so widths stay legal with no bounce.
    localparam int NPH  = (BOUNCE_TOGGLES > 0) ? 2 * BOUNCE_TOGGLES - 1 : 1;
    localparam int PH_W = (NPH > 1) ? $clog2(NPH) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(NPH - 1);

    // One tick counter serves both bounce phases and the gap.
    localparam int TC_MAX = (BOUNCE_TICKS > GAP_TICKS) ? BOUNCE_TICKS : GAP_TICKS;
    localparam int TC_W   = (TC_MAX > 1) ? $clog2(TC_MAX) : 1;
    localparam logic [TC_W-1:0] BNC_LAST = TC_W'(BOUNCE_TICKS - 1);
    localparam logic [TC_W-1:0] GAP_LAST = TC_W'(GAP_TICKS - 1);

    // With no bounce the bounce states are skipped entirely.
    localparam kp_state_e ST_AFTER_ACCEPT = (BOUNCE_TOGGLES > 0) ? ST_BIN  : ST_HOLD;
    localparam kp_state_e ST_AFTER_HOLD   = (BOUNCE_TOGGLES > 0) ? ST_BOUT : ST_GAP;

    kp_state_e         r_state;
    kp_state_e         w_state_nxt;
    logic [PH_W-1:0]   r_phase;
    logic [PH_W-1:0]   w_phase_nxt;
    logic [TC_W-1:0]   r_tcnt;
    logic [TC_W-1:0]   w_tcnt_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;
    logic [HOLD_W-1:0] r_hold_len;
    logic [3:0]        r_code;
    logic [3:0]        r_row;
    logic [3:0]        w_row_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_accept;
    logic              w_tick;
    logic              w_contact;

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_contact = contact_of(r_state, r_phase[0]);
    assign contact   = w_contact;
    assign row       = r_row;
    assign done      = r_done;

    keypad_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_accept),
        .o_tick  (w_tick)
    );

    // Next-state and counter logic: every phase advances only on a tick.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_tcnt_nxt     = r_tcnt;
        w_hold_cnt_nxt = r_hold_cnt;
        w_done_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_phase_nxt    = '0;
                    w_tcnt_nxt     = '0;
                    w_hold_cnt_nxt = '0;
                    w_state_nxt    = ST_AFTER_ACCEPT;
                end
            end
            ST_BIN, ST_BOUT: begin
                if (w_tick) begin
                    if (r_tcnt == BNC_LAST) begin
                        w_tcnt_nxt = '0;
                        if (r_phase == PH_LAST) begin
                            w_phase_nxt = '0;
                            w_state_nxt = (r_state == ST_BIN) ? ST_HOLD : ST_GAP;
                        end else begin
                            w_phase_nxt = r_phase + PH_W'(1);
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + TC_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    // r_hold_len is never 0, so the subtraction cannot wrap.
                    if (r_hold_cnt == r_hold_len - HOLD_W'(1)) begin
                        w_hold_cnt_nxt = '0;
                        w_state_nxt    = ST_AFTER_HOLD;
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    if (r_tcnt == GAP_LAST) begin
                        w_tcnt_nxt  = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_tcnt_nxt = r_tcnt + TC_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; reset drops any command in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_phase    <= '0;
            r_tcnt     <= '0;
            r_hold_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Latch key code and hold length on accept; a hold of 0 behaves as 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_code     <= '0;
            r_hold_len <= HOLD_W'(1);
        end else if (w_accept) begin
            r_code     <= cmd_code;
            r_hold_len <= (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
        end
    end

    // Only the addressed row can be pulled low, and only while its column is strobed.
    always_comb begin
        w_row_nxt = 4'hF;
        if (w_contact && !col[r_code[1:0]]) begin
            w_row_nxt[r_code[3:2]] = 1'b0;
        end
    end

    // Registered row return, one clk behind contact and column.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_row <= 4'hF;
        end else begin
            r_row <= w_row_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: two instances (clean edges and
// 2-toggle bounce). Drivers push an expected per-command summary computed from
// the press timeline; a monitor accumulates contact/row activity and compares
// when each command's done pulse appears.
module tb_keypad_emulator;
    import keypad_emulator_pkg::*;

    localparam int TICK_DIV     = 4;
    localparam int BOUNCE_TICKS = 1;
    localparam int GAP_TICKS    = 2;
    localparam int HOLD_W       = 16;
    localparam int LIMIT        = 400;

    typedef struct {
        int         done_cyc;
        int         contact_cyc;
        int         edges;
        int         row_low;
        int         row_fall;
        logic [1:0] row_idx;
        bit         chk_row;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid [2];
    logic [3:0]        cmd_code  [2];
    logic [HOLD_W-1:0] cmd_hold  [2];
    logic [3:0]        col       [2];
    logic              cmd_ready [2];
    logic              busy      [2];
    logic              contact   [2];
    logic              done      [2];
    logic [3:0]        row       [2];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    txn_t sb_q [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keypad_emulator #(
        .TICK_DIV(TICK_DIV), .BOUNCE_TOGGLES(0), .BOUNCE_TICKS(BOUNCE_TICKS),
        .GAP_TICKS(GAP_TICKS), .HOLD_W(HOLD_W)
    ) u_dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_code(cmd_code[0]), .cmd_hold(cmd_hold[0]), .col(col[0]), .row(row[0]),
        .busy(busy[0]), .contact(contact[0]), .done(done[0])
    );

    keypad_emulator #(
        .TICK_DIV(TICK_DIV), .BOUNCE_TOGGLES(2), .BOUNCE_TICKS(BOUNCE_TICKS),
        .GAP_TICKS(GAP_TICKS), .HOLD_W(HOLD_W)
    ) u_dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_code(cmd_code[1]), .cmd_hold(cmd_hold[1]), .col(col[1]), .row(row[1]),
        .busy(busy[1]), .contact(contact[1]), .done(done[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int bt_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    // Expected command summary from the press timeline, built as a list of
    // (contact level, duration in ticks) segments.
    function automatic txn_t model(input int d, input logic [3:0] code,
                                   input logic [HOLD_W-1:0] hold, input logic [3:0] c,
                                   input int a, input bit chk_row);
        txn_t t;
        bit   seg_v [$];
        int   seg_k [$];
        int   b      = bt_of(d);
        int   h      = (hold == '0) ? 1 : int'(hold);
        int   ticks  = 0;
        int   closed = 0;
        int   edges  = 0;
        bit   prev   = 1'b0;
        bit   addressed;
        for (int p = 0; p < 2 * b - 1; p++) begin
            seg_v.push_back(p % 2 == 0); seg_k.push_back(BOUNCE_TICKS);
        end
        seg_v.push_back(1'b1); seg_k.push_back(h);
        for (int p = 0; p < 2 * b - 1; p++) begin
            seg_v.push_back(p % 2 == 1); seg_k.push_back(BOUNCE_TICKS);
        end
        seg_v.push_back(1'b0); seg_k.push_back(GAP_TICKS);
        for (int i = 0; i < seg_v.size(); i++) begin
            if (seg_v[i] && !prev) edges++;
            if (seg_v[i]) closed += seg_k[i];
            ticks += seg_k[i];
            prev = seg_v[i];
        end
        addressed     = (c[code[1:0]] == 1'b0);
        t.done_cyc    = a + ticks * TICK_DIV;
        t.contact_cyc = closed * TICK_DIV;
        t.edges       = edges;
        t.row_low     = addressed ? t.contact_cyc : 0;
        t.row_fall    = addressed ? edges : 0;
        t.row_idx     = code[3:2];
        t.chk_row     = chk_row;
        return t;
    endfunction

    // Present a command (called at a negedge); returns at the negedge after the accept edge.
    task automatic send(input int d, input logic [3:0] code, input logic [HOLD_W-1:0] hold,
                        input bit chk_row, input bit keep_valid,
                        output int acc_cyc, output int exp_done);
        txn_t t;
        bit   ok = 1'b0;
        acc_cyc  = -1;
        exp_done = -1;
        cmd_code[d]  = code;
        cmd_hold[d]  = hold;
        cmd_valid[d] = 1'b1;
        for (int w = 0; w < LIMIT && !ok; w++) begin
            if (cmd_ready[d]) begin
                t = model(d, code, hold, col[d], cyc + 1, chk_row);
                sb_q[d].push_back(t);
                acc_cyc  = cyc;
                exp_done = t.done_cyc;
                ok = 1'b1;
            end
            @(negedge clk);
        end
        if (!keep_valid) cmd_valid[d] = 1'b0;
        if (!ok) check($sformatf("d%0d_accept_timeout", d), ok, 1);
    endtask

    task automatic wait_idle(input int d);
        bit ok = 1'b0;
        for (int w = 0; w < LIMIT && !ok; w++) begin
            if (cmd_ready[d] && sb_q[d].size() == 0) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) check($sformatf("d%0d_idle_timeout", d), ok, 1);
    endtask

    task automatic run_random(input int d, input int n);
        logic [3:0]        code;
        logic [3:0]        c;
        logic [HOLD_W-1:0] hold;
        bit                b2b = 1'b0;
        int                a, e;
        for (int i = 0; i < n; i++) begin
            code = 4'($urandom_range(0, 15));
            hold = HOLD_W'($urandom_range(0, 4));
            if (!b2b) begin
                wait_idle(d);
                c = 4'($urandom);
                if ($urandom_range(0, 3) != 0) c[code[1:0]] = 1'b0;
                col[d] = c;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            b2b = ($urandom_range(0, 2) != 0) && (i != n - 1);
            send(d, code, hold, 1'b1, b2b, a, e);
        end
    endtask

    // Monitor: accumulate activity per command and score it on each done pulse.
    int       acc_c  [2];
    int       acc_e  [2];
    int       acc_rl [2];
    int       acc_rf [2];
    int       acc_st [2];
    logic     prev_c [2];
    logic [3:0] prev_row [2];
    txn_t     mt;

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst !== 1'b1) begin
                sb_q[g].delete();
                acc_c[g] = 0; acc_e[g] = 0; acc_rl[g] = 0; acc_rf[g] = 0; acc_st[g] = 0;
                prev_c[g] = 1'b0; prev_row[g] = 4'hF;
            end else begin
                if (contact[g] === 1'b1) begin
                    acc_c[g]++;
                    if (!prev_c[g]) acc_e[g]++;
                end
                if (sb_q[g].size() > 0) begin
                    for (int r = 0; r < 4; r++) begin
                        if (row[g][r] !== 1'b1) begin
                            if (r == int'(sb_q[g][0].row_idx)) begin
                                acc_rl[g]++;
                                if (prev_row[g][r]) acc_rf[g]++;
                            end else begin
                                acc_st[g]++;
                            end
                        end
                    end
                end else if (row[g] !== 4'hF) begin
                    acc_st[g]++;
                end
                if (done[g] === 1'b1) begin
                    if (sb_q[g].size() == 0) begin
                        check($sformatf("d%0d_unexpected_done", g), done[g], 0);
                    end else begin
                        mt = sb_q[g].pop_front();
                        check($sformatf("d%0d_done_cycle", g), cyc, mt.done_cyc);
                        check($sformatf("d%0d_contact_cycles", g), acc_c[g], mt.contact_cyc);
                        check($sformatf("d%0d_contact_closures", g), acc_e[g], mt.edges);
                        if (mt.chk_row) begin
                            check($sformatf("d%0d_row_low_cycles", g), acc_rl[g], mt.row_low);
                            check($sformatf("d%0d_row_falls", g), acc_rf[g], mt.row_fall);
                            check($sformatf("d%0d_stray_rows", g), acc_st[g], 0);
                        end
                    end
                    acc_c[g] = 0; acc_e[g] = 0; acc_rl[g] = 0; acc_rf[g] = 0; acc_st[g] = 0;
                end
                prev_c[g]   = contact[g];
                prev_row[g] = row[g];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat [4];
        logic [3:0] exp_row;
        int a1, d1, a2, d2, n_done;
        pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0; cmd_code[d] = '0; cmd_hold[d] = '0; col[d] = 4'hF;
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_rst_row", d), row[d], 4'hF);
            check($sformatf("d%0d_rst_ready", d), cmd_ready[d], 1);
            check($sformatf("d%0d_rst_busy", d), busy[d], 0);
            check($sformatf("d%0d_rst_contact", d), contact[d], 0);
            check($sformatf("d%0d_rst_done", d), done[d], 0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Clean press of Key_Up, hold 3, column 2 strobed
        col[0] = 4'b1011;
        send(0, KEY_UP, 3, 1'b1, 1'b0, a1, d1);
        check("clean_contact_after_accept", contact[0], 1);
        check("clean_ready_low", cmd_ready[0], 0);
        wait_idle(0);
        check("clean_ready_after_done", cmd_ready[0], 1);

        // Column scanning during HOLD: row follows the previous clk's column
        col[0] = 4'hF;
        send(0, KEY_UP, 8, 1'b0, 1'b0, a1, d1);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            col[0] = pat[i % 4];
            exp_row = (pat[i % 4][2] == 1'b0) ? 4'b1101 : 4'hF;
            @(negedge clk);
            check($sformatf("scan_row_%0d", i), row[0], exp_row);
        end
        col[0] = 4'hF;
        wait_idle(0);

        // Bounced press of Key_Left
        col[1] = 4'b1101;
        send(1, KEY_LEFT, 2, 1'b1, 1'b0, a1, d1);
        wait_idle(1);

        // Busy: second request held through the first command, taken in its done cycle
        col[0] = 4'b0000;
        send(0, KEY_DOWN, 2, 1'b1, 1'b1, a1, d1);
        check("busy_ready_low", cmd_ready[0], 0);
        check("busy_flag", busy[0], 1);
        send(0, KEY_RIGHT, 1, 1'b1, 1'b0, a2, d2);
        check("b2b_accept_cycle", a2, d1);
        wait_idle(0);

        // Reset during HOLD, then a hold=0 command
        col[0] = 4'b1011;
        send(0, KEY_UP, 5, 1'b1, 1'b0, a1, d1);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_row", row[0], 4'hF);
        check("midrst_contact", contact[0], 0);
        check("midrst_busy", busy[0], 0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done[0] === 1'b1) n_done++;
        end
        check("midrst_no_done", n_done, 0);
        send(0, KEY_UP, 0, 1'b1, 1'b0, a1, d1);
        wait_idle(0);

        // Randomized commands on both instances
        fork
            run_random(0, 20);
            run_random(1, 20);
        join
        wait_idle(0);
        wait_idle(1);
        check("d0_queue_drained", sb_q[0].size(), 0);
        check("d1_queue_drained", sb_q[1].size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
